branch_resolve_tracker: RTL and testbench

Tracks every in-flight conditional branch between dispatch and execute, keyed by one-hot speculative tag. Stores each branch's PHT index, predicted direction and predicted target. On resolution it compares the stored prediction against the actual outcome, then emits one registered bundle: PHT update (`we`, `wcond`, `went`) and speculation verdict (`prmiss`, `prsuccess`, `prtag`). The gshare predictor and the speculative-tag recovery logic consume this bundle. It also kills every entry younger than a mispredicted branch.

---
 rtl/branch_resolve_tracker.sv | 163 ++++++++++++++++
 tb/tb_branch_resolve_tracker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_tracker.sv
// Tracks in-flight conditional branches by one-hot speculative tag and, on resolution,
// emits a registered PHT-update / speculation-verdict bundle and squashes younger entries.
module branch_resolve_tracker #(
   parameter int unsigned NTAG     = 5,
   parameter int unsigned ADDR_LEN = 32,
   parameter int unsigned BHR_LEN  = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alloc_valid,
   input  logic [NTAG-1:0]     alloc_tag,
   input  logic [ADDR_LEN-1:0] alloc_pc,
   input  logic [BHR_LEN-1:0]  alloc_bhr,
   input  logic                alloc_pred,
   input  logic [ADDR_LEN-1:0] alloc_target,
   input  logic                res_valid,
   input  logic [NTAG-1:0]     res_tag,
   input  logic                res_taken,
   input  logic [ADDR_LEN-1:0] res_target,
   output logic                we,
   output logic                wcond,
   output logic [BHR_LEN-1:0]  went,
   output logic                prmiss,
   output logic                prsuccess,
   output logic [NTAG-1:0]     prtag,
   output logic [ADDR_LEN-1:0] redirect_pc,
   output logic [NTAG-1:0]     valid_mask,
   output logic                err
);

   // Per-entry state
   logic [NTAG-1:0]     v_q, v_d;
   logic [NTAG-1:0]     older_q [NTAG];
   logic [NTAG-1:0]     older_d [NTAG];
   logic [BHR_LEN-1:0]  idx_q   [NTAG];
   logic                pred_q  [NTAG];
   logic [ADDR_LEN-1:0] tgt_q   [NTAG];
   logic [ADDR_LEN-1:0] pc4_q   [NTAG];

   // Output bundle registers
   logic                we_q, we_d;
   logic                wcond_q, wcond_d;
   logic [BHR_LEN-1:0]  went_q, went_d;
   logic                prmiss_q, prmiss_d;
   logic                prsuccess_q, prsuccess_d;
   logic [NTAG-1:0]     prtag_q, prtag_d;
   logic [ADDR_LEN-1:0] redirect_q, redirect_d;
   logic                err_q, err_d;

   // Decode helpers
   logic                res_ok, miss, alloc_legal, alloc_ok;
   logic [NTAG-1:0]     kill, clear, freeing;
   logic [BHR_LEN-1:0]  sel_idx;
   logic                sel_pred;
   logic [ADDR_LEN-1:0] sel_tgt, sel_pc4;

   always_comb begin
      sel_idx     = '0;
      sel_pred    = 1'b0;
      sel_tgt     = '0;
      sel_pc4     = '0;
      kill        = '0;
      clear       = '0;
      freeing     = '0;
      v_d         = v_q;
      we_d        = 1'b0;
      wcond_d     = 1'b0;
      went_d      = '0;
      prmiss_d    = 1'b0;
      prsuccess_d = 1'b0;
      prtag_d     = '0;
      redirect_d  = '0;

      res_ok = res_valid && $onehot(res_tag) && ((res_tag & v_q) != '0);

      for (int unsigned i = 0; i < NTAG; i++) begin
         if (res_tag[i]) begin
            sel_idx  = idx_q[i];
            sel_pred = pred_q[i];
            sel_tgt  = tgt_q[i];
            sel_pc4  = pc4_q[i];
         end
         if ((older_q[i] & res_tag) != '0) kill[i] = 1'b1;
      end

      miss = (res_taken != sel_pred) || (res_taken && (res_target != sel_tgt));

      // A freed tag stays occupied for allocation purposes until the next cycle
      alloc_legal = alloc_valid && $onehot(alloc_tag) && ((alloc_tag & v_q) == '0);
      alloc_ok    = alloc_legal && !(res_ok && miss);

      if (res_ok) begin
         freeing     = res_tag;
         clear       = miss ? (res_tag | kill) : res_tag;
         we_d        = 1'b1;
         wcond_d     = res_taken;
         went_d      = sel_idx;
         prmiss_d    = miss;
         prsuccess_d = !miss;
         prtag_d     = res_tag;
         redirect_d  = res_taken ? res_target : sel_pc4;
      end

      v_d = (v_q & ~clear) | (alloc_ok ? alloc_tag : '0);

      for (int unsigned i = 0; i < NTAG; i++) begin
         older_d[i] = older_q[i] & ~freeing;
         if (clear[i]) older_d[i] = '0;
         if (alloc_ok && alloc_tag[i]) older_d[i] = v_q & ~freeing;
      end

      err_d = err_q || (alloc_valid && !alloc_legal) || (res_valid && !res_ok);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q         <= '0;
         we_q        <= 1'b0;
         wcond_q     <= 1'b0;
         went_q      <= '0;
         prmiss_q    <= 1'b0;
         prsuccess_q <= 1'b0;
         prtag_q     <= '0;
         redirect_q  <= '0;
         err_q       <= 1'b0;
         for (int unsigned i = 0; i < NTAG; i++) older_q[i] <= '0;
      end else begin
         v_q         <= v_d;
         we_q        <= we_d;
         wcond_q     <= wcond_d;
         went_q      <= went_d;
         prmiss_q    <= prmiss_d;
         prsuccess_q <= prsuccess_d;
         prtag_q     <= prtag_d;
         redirect_q  <= redirect_d;
         err_q       <= err_d;
         for (int unsigned i = 0; i < NTAG; i++) older_q[i] <= older_d[i];
      end
   end

   // Payload fields are qualified by v, so they need no reset
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NTAG; i++) begin
         if (alloc_ok && alloc_tag[i]) begin
            idx_q[i]  <= alloc_pc[2 +: BHR_LEN] ^ alloc_bhr;
            pred_q[i] <= alloc_pred;
            tgt_q[i]  <= alloc_target;
            pc4_q[i]  <= alloc_pc + ADDR_LEN'(4);
         end
      end
   end

   assign we          = we_q;
   assign wcond       = wcond_q;
   assign went        = went_q;
   assign prmiss      = prmiss_q;
   assign prsuccess   = prsuccess_q;
   assign prtag       = prtag_q;
   assign redirect_pc = redirect_q;
   assign valid_mask  = v_q;
   assign err         = err_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed scoreboard bench for branch_resolve_tracker: expected bundles are queued
// when a resolve is driven and checked in the cycle the bundle must appear.
module tb_branch_resolve_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_valid;
   logic [4:0]  alloc_tag;
   logic [31:0] alloc_pc;
   logic [9:0]  alloc_bhr;
   logic        alloc_pred;
   logic [31:0] alloc_target;
   logic        res_valid;
   logic [4:0]  res_tag;
   logic        res_taken;
   logic [31:0] res_target;
   logic        we, wcond, prmiss, prsuccess, err;
   logic [9:0]  went;
   logic [4:0]  prtag, valid_mask;
   logic [31:0] redirect_pc;

   branch_resolve_tracker dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_pc(alloc_pc),
      .alloc_bhr(alloc_bhr), .alloc_pred(alloc_pred), .alloc_target(alloc_target),
      .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
      .res_target(res_target),
      .we(we), .wcond(wcond), .went(went), .prmiss(prmiss), .prsuccess(prsuccess),
      .prtag(prtag), .redirect_pc(redirect_pc), .valid_mask(valid_mask), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        miss;
      logic        wcond;
      logic [9:0]  went;
      logic [4:0]  tag;
      logic [31:0] rpc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic check_bundle();
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("we", 32'(we), 32'd1);
         chk("prmiss", 32'(prmiss), 32'(e.miss));
         chk("prsuccess", 32'(prsuccess), 32'(!e.miss));
         chk("wcond", 32'(wcond), 32'(e.wcond));
         chk("went", 32'(went), 32'(e.went));
         chk("prtag", 32'(prtag), 32'(e.tag));
         if (e.miss) chk("redirect_pc", redirect_pc, e.rpc);
      end else begin
         chk("idle_we", 32'(we), 32'd0);
         chk("idle_prmiss", 32'(prmiss), 32'd0);
         chk("idle_prsuccess", 32'(prsuccess), 32'd0);
         chk("idle_prtag", 32'(prtag), 32'd0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      alloc_valid = 1'b0;
      res_valid   = 1'b0;
      check_bundle();
   endtask

   task automatic do_alloc(input logic [4:0] t, input logic [31:0] pc, input logic [9:0] bhr,
                           input logic p, input logic [31:0] tg);
      alloc_valid  = 1'b1;
      alloc_tag    = t;
      alloc_pc     = pc;
      alloc_bhr    = bhr;
      alloc_pred   = p;
      alloc_target = tg;
   endtask

   task automatic do_res(input logic [4:0] t, input logic tk, input logic [31:0] tg);
      res_valid  = 1'b1;
      res_tag    = t;
      res_taken  = tk;
      res_target = tg;
   endtask

   task automatic expect_bundle(input logic miss, input logic wc, input logic [9:0] wi,
                                input logic [4:0] t, input logic [31:0] rpc);
      exp_t e;
      e.miss = miss; e.wcond = wc; e.went = wi; e.tag = t; e.rpc = rpc;
      q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; alloc_valid = 1'b0; res_valid = 1'b0;
      alloc_tag = '0; alloc_pc = '0; alloc_bhr = '0; alloc_pred = 1'b0; alloc_target = '0;
      res_tag = '0; res_taken = 1'b0; res_target = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_mask", 32'(valid_mask), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_went", 32'(went), 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_wcond", 32'(wcond), 32'd0);

      // Correct prediction
      do_alloc(5'b00001, 32'h100, 10'h3FF, 1'b1, 32'h200); step();
      chk("t1_mask_alloc", 32'(valid_mask), 32'b00001);
      do_res(5'b00001, 1'b1, 32'h200); expect_bundle(1'b0, 1'b1, 10'h3BF, 5'b00001, 32'h200); step();
      chk("t1_mask", 32'(valid_mask), 32'd0);

      // Direction miss flushes the younger entry
      do_alloc(5'b00001, 32'h100, 10'h0, 1'b1, 32'h200); step();
      do_alloc(5'b00010, 32'h300, 10'h0, 1'b1, 32'h400); step();
      do_alloc(5'b00100, 32'h500, 10'h0, 1'b1, 32'h600); step();
      chk("t2_mask_full", 32'(valid_mask), 32'b00111);
      do_res(5'b00010, 1'b0, 32'h0); expect_bundle(1'b1, 1'b0, 10'h0C0, 5'b00010, 32'h304); step();
      chk("t2_mask", 32'(valid_mask), 32'b00001);
      do_res(5'b00001, 1'b1, 32'h200); expect_bundle(1'b0, 1'b1, 10'h040, 5'b00001, 32'h200); step();
      chk("t2_mask_empty", 32'(valid_mask), 32'd0);

      // Target miss
      do_alloc(5'b01000, 32'h100, 10'h001, 1'b1, 32'h200); step();
      do_res(5'b01000, 1'b1, 32'h280); expect_bundle(1'b1, 1'b1, 10'h041, 5'b01000, 32'h280); step();
      chk("t3_mask", 32'(valid_mask), 32'd0);

      // Same-cycle hit + alloc: new entry must not count the freed tag as older
      do_alloc(5'b00001, 32'h100, 10'h0, 1'b0, 32'h0); step();
      do_res(5'b00001, 1'b0, 32'h0);
      do_alloc(5'b00010, 32'h200, 10'h0, 1'b0, 32'h0);
      expect_bundle(1'b0, 1'b0, 10'h040, 5'b00001, 32'h104); step();
      chk("t4a_mask", 32'(valid_mask), 32'b00010);
      do_alloc(5'b00001, 32'h700, 10'h0, 1'b0, 32'h0); step();
      chk("t4a_mask2", 32'(valid_mask), 32'b00011);
      do_res(5'b00001, 1'b1, 32'h900); expect_bundle(1'b1, 1'b1, 10'h1C0, 5'b00001, 32'h900); step();
      chk("t4a_mask3", 32'(valid_mask), 32'b00010);
      do_res(5'b00010, 1'b1, 32'h222); expect_bundle(1'b1, 1'b1, 10'h080, 5'b00010, 32'h222); step();
      chk("t4a_mask4", 32'(valid_mask), 32'd0);

      // Same-cycle miss + alloc: allocation dropped, not an error
      do_alloc(5'b00001, 32'h100, 10'h0, 1'b1, 32'h200); step();
      do_res(5'b00001, 1'b0, 32'h0);
      do_alloc(5'b00010, 32'h200, 10'h0, 1'b0, 32'h0);
      expect_bundle(1'b1, 1'b0, 10'h040, 5'b00001, 32'h104); step();
      chk("t4b_mask", 32'(valid_mask), 32'd0);
      chk("t4b_err", 32'(err), 32'd0);

      // Protocol errors
      do_alloc(5'b00001, 32'h100, 10'h0, 1'b1, 32'h200); step();
      do_alloc(5'b00001, 32'h900, 10'h0, 1'b0, 32'h0); step();
      chk("t5_err", 32'(err), 32'd1);
      chk("t5_mask", 32'(valid_mask), 32'b00001);
      do_res(5'b00001, 1'b1, 32'h200); expect_bundle(1'b0, 1'b1, 10'h040, 5'b00001, 32'h200); step();
      do_res(5'b00100, 1'b1, 32'h0); step();
      chk("t5_err_hold", 32'(err), 32'd1);
      do_alloc(5'b10000, 32'h100, 10'h0, 1'b1, 32'h200); step();
      chk("t5_mask_pre", 32'(valid_mask), 32'b10000);
      reset = 1'b1; step(); reset = 1'b0;
      chk("t5_rst_err", 32'(err), 32'd0);
      chk("t5_rst_mask", 32'(valid_mask), 32'd0);

      // Full occupancy then in-order hits
      for (int i = 0; i < 5; i++) begin
         do_alloc(5'(1 << i), 32'h1000 + 32'(i * 16), 10'h0, 1'b1, 32'h2000); step();
      end
      chk("t6_full", 32'(valid_mask), 32'b11111);
      do_alloc(5'b00001, 32'h100, 10'h0, 1'b1, 32'h0); step();
      chk("t6_over_err", 32'(err), 32'd1);
      chk("t6_over_mask", 32'(valid_mask), 32'b11111);
      for (int i = 0; i < 5; i++) begin
         logic [4:0] m;
         do_res(5'(1 << i), 1'b1, 32'h2000);
         expect_bundle(1'b0, 1'b1, 10'(4 * i), 5'(1 << i), 32'h2000); step();
         m = 5'b11111 << (i + 1);
         chk("t6_mask_step", 32'(valid_mask), 32'(m));
      end

      step();
      chk("end_queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
